// File: rtl/kn16_rr_arbiter.sv
// Round-robin front end sharing one combinational W-bit adder between NUM_REQ requesters.
// Operands are registered toward the adder and the sum is registered into a tagged response.
module kn16_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 16,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W:0]           add_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W:0]           rsp_sum,
    output logic [15:0]          op_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W:0]     rsp_sum_q, rsp_sum_d;
    logic [15:0]    op_count_q, op_count_d;

    logic [W-1:0]   a_arr [NUM_REQ];
    logic [W-1:0]   b_arr [NUM_REQ];
    logic [IDW-1:0] winner;
    logic [IW-1:0]  win_sel;
    logic           any_valid;
    logic           accept;
    logic           grant;
    int             idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*W +: W];
        assign b_arr[gi] = req_b[gi*W +: W];
    end

    // Scan from farthest to nearest so the requester closest after last_grant wins.
    always_comb begin
        winner    = '0;
        win_sel   = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[IW'(idx)]) begin
                winner    = IDW'(idx);
                win_sel   = IW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign accept    = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign grant     = accept && any_valid;
    assign req_ready = grant ? (NUM_REQ'(1) << win_sel) : '0;

    always_comb begin
        state_d      = state_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        op_count_d   = op_count_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rsp_sum_d   = add_sum;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d  = op_count_q + 16'd1;
                    rsp_valid_d = 1'b0;
                    state_d     = grant ? EVAL : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant) begin
            add_a_d      = a_arr[win_sel];
            add_b_d      = b_arr[win_sel];
            id_d         = winner;
            last_grant_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            add_a_q      <= '0;
            add_b_q      <= '0;
            id_q         <= '0;
            last_grant_q <= LAST_RST;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            op_count_q   <= op_count_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_kn16_rr_arbiter.sv
// Self-checking bench for kn16_rr_arbiter: vector table, directed corner sequences,
// and a randomized run against a latency/queue-based reference model.
module tb_kn16_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [W-1:0]     add_a, add_b;
    logic [W:0]       add_sum;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [W:0]       rsp_sum;
    logic [15:0]      op_count;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    typedef struct {
        int          id;
        logic [16:0] sum;
        int          t;
    } exp_t;

    vec_t tbl [6];
    exp_t q [$];

    kn16_rr_arbiter #(.NUM_REQ(N), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .op_count  (op_count)
    );

    // Stand-in for the shared combinational adder beside the arbiter.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    // One isolated operation starting from IDLE; rsp_ready held low until the result shows.
    task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] sum);
        @(negedge clk);
        set_req(id, a, b);
        req_valid = N'(1) << id;
        rsp_ready = 1'b0;
        #1;
        chk("op_ready", 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("op_eval_valid", 32'(rsp_valid), 32'd0);
        chk("op_add_a", 32'(add_a), 32'(a));
        chk("op_add_b", 32'(add_b), 32'(b));
        @(negedge clk);
        #1;
        chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("op_rsp_id", 32'(rsp_id), 32'(id));
        chk("op_rsp_sum", 32'(rsp_sum), 32'(sum));
        $display("op id=%0d a=0x%04h b=0x%04h sum=0x%05h", id, a, b, rsp_sum);
        rsp_ready = 1'b1;
        exp_count++;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("op_valid_drop", 32'(rsp_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(exp_count[15:0]));
    endtask

    initial begin
        int mlast, mcount, cyc, ew;
        logic [N-1:0] hold;
        logic ev, acc;
        logic [N-1:0] er;
        exp_t e;

        tbl[0] = '{2, 16'hFFFF, 16'h0001, 17'h10000};
        tbl[1] = '{0, 16'h0000, 16'h0000, 17'h00000};
        tbl[2] = '{1, 16'h1234, 16'h4321, 17'h05555};
        tbl[3] = '{3, 16'h8000, 16'h8000, 17'h10000};
        tbl[4] = '{0, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        tbl[5] = '{3, 16'hAAAA, 16'h5555, 17'h0FFFF};

        // Reset values, and no ready while reset is held
        #2 rst_n = 1'b0;
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_op(tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].sum);
        end

        // Round robin with all requesters valid and the consumer always ready
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 16'hF000 + 16'(i), 16'h1000);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("rr_ready", 32'(req_ready), (c % 2 == 0) ? (32'(1) << ((c / 2) % N)) : 32'd0);
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(c >= 2 && c % 2 == 0));
            chk("rr_op_count", 32'(op_count), 32'(exp_count[15:0]));
            if (c >= 2 && c % 2 == 0) begin
                chk("rr_rsp_id", 32'(rsp_id), 32'((c / 2 - 1) % N));
                chk("rr_rsp_sum", 32'(rsp_sum), 32'h10000 + 32'((c / 2 - 1) % N));
                $display("rr grant id=%0d sum=0x%05h", rsp_id, rsp_sum);
                exp_count++;
            end
        end

        // Backpressure on the result of requester 0
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_sum", 32'(rsp_sum), 32'h10000);
            chk("bp_add_a", 32'(add_a), 32'hF000);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        chk("bp_op_count", 32'(op_count), 32'(exp_count[15:0]));
        $display("bp release id=%0d sum=0x%05h", rsp_id, rsp_sum);
        exp_count++;
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("bp_after_valid", 32'(rsp_valid), 32'd0);
        chk("bp_after_count", 32'(op_count), 32'(exp_count[15:0]));

        // Sparse fairness: last grant = 1, only requesters 1 and 3 valid
        do_reset();
        run_op(1, 16'h0001, 16'h0002, 17'h00003);
        @(negedge clk);
        set_req(1, 16'h0011, 16'h0001);
        set_req(3, 16'h0033, 16'h0003);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c % 2 == 0) begin
                chk("sp_ready", 32'(req_ready), (c == 2) ? 32'b0010 : 32'b1000);
                $display("sparse grant ready=%b", req_ready);
            end else begin
                chk("sp_ready_idle", 32'(req_ready), 32'd0);
            end
        end
        req_valid = '0;

        // Reset during EVAL discards the in-flight result
        do_reset();
        @(negedge clk);
        set_req(2, 16'h1234, 16'h4321);
        req_valid = 4'b0100;
        #1;
        chk("mf_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("mf_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mf_op_count", 32'(op_count), 32'd0);
        chk("mf_add_a", 32'(add_a), 32'd0);
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("mf_ready_in_reset", 32'(req_ready), 32'd0);
        chk("mf_rsp_valid2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        #1;
        chk("mf_first_grant", 32'(req_ready), 32'b0001);
        chk("mf_rsp_valid3", 32'(rsp_valid), 32'd0);
        $display("midflight reset: first grant ready=%b", req_ready);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mf_rsp_valid4", 32'(rsp_valid), 32'd0);

        // op_count wrap
        do_reset();
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        #1;
        chk("wrap_preload", 32'(op_count), 32'hFFFF);
        exp_count = 65535;
        run_op(3, 16'h8000, 16'h8000, 17'h10000);

        // Randomized traffic against a queue/latency model
        do_reset();
        mlast = N - 1;
        mcount = 0;
        cyc = 0;
        hold = '0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    set_req(i, 16'($urandom), 16'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            ev = (q.size() > 0) && ((cyc - q[0].t) >= 2);
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rnd_rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rnd_rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
            end
            chk("rnd_op_count", 32'(op_count), 32'(mcount[15:0]));
            acc = (q.size() == 0) || (ev && rsp_ready);
            ew = -1;
            for (int k = 1; k <= N; k++) begin
                if (ew < 0 && req_valid[(mlast + k) % N]) ew = (mlast + k) % N;
            end
            er = (acc && ew >= 0) ? (N'(1) << ew) : '0;
            chk("rnd_req_ready", 32'(req_ready), 32'(er));
            if (ev && rsp_ready) begin
                $display("rnd rsp id=%0d sum=0x%05h", q[0].id, q[0].sum);
                void'(q.pop_front());
                mcount++;
            end
            if (er != '0) begin
                e.id  = ew;
                e.sum = 17'(req_a[ew*W +: W]) + 17'(req_b[ew*W +: W]);
                e.t   = cyc;
                q.push_back(e);
                mlast = ew;
            end
            hold = req_valid & ~er;
            cyc++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kn16_rr_arbiter.md
Name: kn16_rr_arbiter

Overview:
- Shares one combinational 16-bit adder between NUM_REQ requesters using round-robin arbitration.
- Each requester has its own valid/ready operand channel. All requesters share one valid/ready response channel, and each result is tagged with the requester id.
- The block drives the adder operand ports from registers and captures the adder result into a response register.
- It sits beside the adder instance. The mapping from vector bits to the adder's scalar pins is done at the instance site.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 16, operand width; must match the shared adder.
- IDW, 2, width of the requester id; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NUM_REQ*W  operand B, same packing as req_a.
- add_a  out  W  registered operand A to the adder; bit 0 is the LSB.
- add_b  out  W  registered operand B to the adder.
- add_sum  in  W+1  adder result; bit W is the carry-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that produced the result.
- rsp_sum  out  W+1  registered sum, with carry in bit W.
- op_count  out  16  count of completed response handshakes; wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - add_a, add_b = 0.
  - rsp_valid = 0; rsp_id = 0; rsp_sum = 0.
  - op_count = 0.
  - last_grant = NUM_REQ-1, so requester 0 has highest priority first.
  - req_ready = 0 while rst_n is low.
- Arbitration:
  - The winner is the first i with req_valid[i] = 1, scanning from last_grant+1 upward modulo NUM_REQ.
  - last_grant updates only on an accepted operand handshake.
- accept condition: (state == IDLE) or (state == RESP and rsp_ready).
- req_ready[i] = accept and (i is the winner). This is combinational from req_valid, state and rsp_ready; all other bits are 0.
- States:
  - IDLE: if any req_valid is high, accept the winner. Capture its req_a and req_b into add_a and add_b, capture its id, then go to EVAL. Otherwise stay in IDLE.
  - EVAL (one cycle; the adder settles on the registered operands): at the clock edge, rsp_sum <= add_sum, rsp_id <= the captured id, rsp_valid <= 1, then go to RESP.
  - RESP: rsp_valid is held high. rsp_sum and rsp_id are stable until the handshake.
    - On rsp_ready: op_count increments (wrapping 0xFFFF to 0).
    - On rsp_ready with a request pending: accept it in the same cycle, go to EVAL, and rsp_valid falls to 0 next cycle.
    - On rsp_ready with no request pending: go to IDLE and rsp_valid falls.
    - Without rsp_ready: stay in RESP, accept nothing, and keep add_a/add_b unchanged.
- Latency: operand handshake in cycle t gives rsp_valid = 1 in cycle t+2.
- Throughput: with rsp_ready held high, one result every 2 cycles.
- add_a and add_b change only on an accepted operand handshake. They are held through EVAL and RESP.
- Arithmetic: rsp_sum = req_a + req_b as an unsigned (W+1)-bit value. There is no carry-in.
- Simultaneous events:
  - The response handshake and a new operand accept in the same cycle are both honoured.
  - The op_count increment and last_grant update in the same cycle are independent.
- A requester that drops req_valid without a handshake is not an error; it simply loses arbitration.
- A requester must hold req_valid and its operands stable until req_ready.
- Reset mid-operation (any state): everything returns to its reset value immediately. The in-flight result is discarded and no response is produced.
- Out-of-range ids (i >= NUM_REQ) are never generated.

Test Plan:
- Single op: reset, then requester 2 sends a=0xFFFF, b=0x0001 → req_ready[2] high for 1 cycle; 2 cycles later rsp_valid=1, rsp_sum=0x10000, rsp_id=2, op_count becomes 1 after the handshake.
- Round robin: all 4 req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0; each rsp_id matches its grant and results arrive every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles while a result is held → rsp_sum and rsp_id stable, req_ready all 0, add_a unchanged; on release, the next grant occurs in the handshake cycle.
- Sparse fairness: only requesters 1 and 3 valid, with last_grant=1 → grant 3, then 1, then 3.
- Reset mid-flight: assert rst_n=0 during EVAL of a=0x1234, b=0x4321 → rsp_valid stays 0, op_count=0, and the next grant goes to requester 0 first.
- Wrap: preload 65535 handshakes (or force op_count to 0xFFFF), complete one op → op_count=0x0000; sum 0x8000+0x8000 → rsp_sum=0x10000.
